counter_gate: RTL and testbench
===============================

Name: counter_gate

Overview:
- Upstream control stage for the 12-bit `counter` block: generates its `i_en` and `i_clear` inputs.
- On a start request it issues a one-cycle clear pulse, then emits prescaled enable strobes for a programmed number of strobes (the measurement window), then signals completion.
- Sits between software/test control and the counter inside the sandbox wrapper; `o_en` and `o_clear` connect directly to the counter's `i_en` and `i_clear`.

Parameters:
- PRESCALE_WIDTH, 8: width of the prescale divisor input and internal prescale counter.
- WINDOW_WIDTH, 16: width of the window length input and internal strobe counter.

Ports:
- i_clk  input  1  single clock; all logic rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_stop  input  1  abort request; honoured in any state.
- i_prescale  input  PRESCALE_WIDTH  strobe period minus one; latched on accepted start.
- i_window  input  WINDOW_WIDTH  number of enable strobes per run; latched on accepted start.
- o_en  output  1  one-cycle enable strobe to the counter.
- o_clear  output  1  one-cycle clear pulse to the counter.
- o_busy  output  1  high in CLEAR and RUN.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- FSM states IDLE, CLEAR, RUN, DONE. Registered state; all outputs decoded from registered state and counters only, with no combinational path from inputs.
- Reset: state=IDLE, prescale counter=0, strobe counter=0, latched prescale/window=0. All outputs are 0 during and after reset.
- IDLE:
  - i_start=1 and i_stop=0 -> latch i_prescale/i_window, next=CLEAR.
  - i_start=1 and i_stop=1 in the same cycle -> stop wins; remain IDLE.
- CLEAR (exactly 1 cycle): o_clear=1. Zero both counters.
  - Latched window==0 -> next=DONE, with no o_en ever asserted.
  - Otherwise next=RUN.
- RUN:
  - Prescale counter increments each cycle, starting at 0 on the first RUN cycle.
  - o_en=1 in a cycle where prescale counter == latched prescale; the counter wraps to 0 on that cycle.
  - Strobe counter increments on each o_en.
  - When the o_en just issued is the W-th one (W=latched window), next=DONE.
  - Prescale==0 -> o_en high every RUN cycle, so RUN lasts exactly W cycles.
- Strobe timing: with start sampled at cycle t, CLEAR is at t+1 and the first o_en is at t+2+P. Subsequent strobes follow every P+1 cycles.
- DONE (exactly 1 cycle): o_done=1, next=IDLE.
- i_stop in CLEAR, RUN or DONE -> next=IDLE immediately.
  - o_en/o_clear/o_done are not asserted in the following cycle.
  - o_done is not generated by an aborted run.
  - Outputs in the stop cycle itself follow the current state.
- i_start outside IDLE is ignored. i_prescale/i_window changes after latch have no effect on the current run.
- Counter widths: internal counters equal their parameter widths. Max window 2^WINDOW_WIDTH-1 strobes; no overflow is possible because termination occurs at equality.
- i_rst mid-run -> IDLE next cycle with all outputs 0. Equivalent to stop, plus latched values cleared.

Optional Feature:
- Macro COUNTER_GATE_AUTORELOAD_EN.
- Defined: DONE transitions to CLEAR instead of IDLE, so the block runs back-to-back windows using the same latched prescale/window. o_done still pulses once per window, and o_busy drops only for the DONE cycle. Only i_stop or i_rst returns the block to IDLE.
- Undefined: DONE -> IDLE as specified above; no reload logic is synthesised.

Test Plan:
- Reset: hold i_rst 3 cycles with i_start=1 -> all outputs 0; IDLE after release; start accepted only on the first cycle with i_rst=0.
- Nominal: P=2, W=3, start at cycle 0 -> o_clear@1, o_busy 1..10, o_en@4,7,10, o_done@11, IDLE@12.
- Edge values: P=0, W=4 -> o_en@2,3,4,5, o_done@6. Separately W=0 -> o_clear@1, o_done@2, no o_en.
- Abort: P=1, W=5, assert i_stop at cycle 5 -> o_en seen only @3,5; no o_en/o_done afterward; IDLE@6. Simultaneous start+stop in IDLE -> no o_clear.
- Ignored inputs: pulse i_start and change i_prescale/i_window during RUN -> strobe spacing and count unchanged.
- Autoreload (macro defined): P=0, W=2 -> o_clear@1, o_en@2,3, o_done@4, o_clear@5, o_en@6,7, o_done@8; i_stop@9 -> IDLE@10.

Source files
------------

// File: rtl/counter_gate_if.sv
// Control/strobe bundle between the test controller and the counter_gate block.
interface counter_gate_if #(
    parameter int PRESCALE_WIDTH = 8,
    parameter int WINDOW_WIDTH   = 16
);
    logic                      i_start;
    logic                      i_stop;
    logic [PRESCALE_WIDTH-1:0] i_prescale;
    logic [WINDOW_WIDTH-1:0]   i_window;
    logic                      o_en;
    logic                      o_clear;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output i_start, i_stop, i_prescale, i_window,
        input  o_en, o_clear, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_prescale, i_window,
        output o_en, o_clear, o_busy, o_done
    );
endinterface

// File: rtl/counter_gate.sv
// Clear/enable sequencer for the 12-bit counter: one clear pulse, W prescaled strobes, done pulse.
// Optional back-to-back windows when COUNTER_GATE_AUTORELOAD_EN is defined.
module counter_gate #(
    parameter int PRESCALE_WIDTH = 8,
    parameter int WINDOW_WIDTH   = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    counter_gate_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [PRESCALE_WIDTH-1:0] pcnt_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [WINDOW_WIDTH-1:0]   scnt_r;
    logic [WINDOW_WIDTH-1:0]   window_r;
    logic                      strobe_s;
    logic                      last_s;

    // Strobe fires when the prescale counter reaches the latched period; last marks the W-th strobe.
    always_comb begin
        strobe_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == RUN) begin
            strobe_s = (pcnt_r == prescale_r);
            last_s   = ((scnt_r + WINDOW_WIDTH'(1)) == window_r);
        end else begin
            strobe_s = 1'b0;
            last_s   = 1'b0;
        end
    end

    // Next-state decode; stop overrides everything, including a same-cycle start.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.i_start && !bus.i_stop) state_s = CLEAR;
                else                            state_s = IDLE;
            end
            CLEAR: begin
                if (bus.i_stop)                      state_s = IDLE;
                else if (window_r == WINDOW_WIDTH'(0)) state_s = DONE;
                else                                 state_s = RUN;
            end
            RUN: begin
                if (bus.i_stop)            state_s = IDLE;
                else if (strobe_s && last_s) state_s = DONE;
                else                       state_s = RUN;
            end
            DONE: begin
                if (bus.i_stop) state_s = IDLE;
`ifdef COUNTER_GATE_AUTORELOAD_EN
                else            state_s = CLEAR;
`else
                else            state_s = IDLE;
`endif
            end
            default: state_s = IDLE;
        endcase
    end

    // State, latched run parameters and the prescale/strobe counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            pcnt_r     <= PRESCALE_WIDTH'(0);
            scnt_r     <= WINDOW_WIDTH'(0);
            prescale_r <= PRESCALE_WIDTH'(0);
            window_r   <= WINDOW_WIDTH'(0);
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && (state_s == CLEAR)) begin
                prescale_r <= bus.i_prescale;
                window_r   <= bus.i_window;
            end else begin
                prescale_r <= prescale_r;
                window_r   <= window_r;
            end
            case (state_r)
                CLEAR: begin
                    pcnt_r <= PRESCALE_WIDTH'(0);
                    scnt_r <= WINDOW_WIDTH'(0);
                end
                RUN: begin
                    if (strobe_s) begin
                        pcnt_r <= PRESCALE_WIDTH'(0);
                        scnt_r <= scnt_r + WINDOW_WIDTH'(1);
                    end else begin
                        pcnt_r <= pcnt_r + PRESCALE_WIDTH'(1);
                        scnt_r <= scnt_r;
                    end
                end
                default: begin
                    pcnt_r <= pcnt_r;
                    scnt_r <= scnt_r;
                end
            endcase
        end
    end

    assign bus.o_en    = strobe_s;
    assign bus.o_clear = (state_r == CLEAR);
    assign bus.o_busy  = (state_r == CLEAR) || (state_r == RUN);
    assign bus.o_done  = (state_r == DONE);
endmodule

// File: tb/tb_counter_gate.sv
// Scoreboard bench for counter_gate: the model schedules expected clear/en/done events per start.
// Define COUNTER_GATE_AUTORELOAD_EN consistently for RTL and bench to exercise back-to-back windows.
module tb_counter_gate;
    localparam int PW = 8;
    localparam int WW = 16;

    typedef struct {
        int cyc;
        int kind;   // 0 = clear, 1 = en, 2 = done
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    ev_t  q[$];
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   m_active = 1'b0;
    int   m_done = 0;
    int   m_p = 0;
    int   m_w = 0;

    counter_gate_if #(.PRESCALE_WIDTH(PW), .WINDOW_WIDTH(WW)) bus ();

    counter_gate #(.PRESCALE_WIDTH(PW), .WINDOW_WIDTH(WW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        else n_pass++;
    endtask

    // One window: clear at tc, strobes every p+1 cycles from tc+1+p, done right after the last strobe.
    task automatic sched(input int tc, input int p, input int w);
        ev_t e;
        int  d;
        e.cyc = tc; e.kind = 0; q.push_back(e);
        for (int k = 0; k < w; k++) begin
            e.cyc = tc + 1 + p + k * (p + 1); e.kind = 1; q.push_back(e);
        end
        d = tc + 1 + w * (p + 1);
        e.cyc = d; e.kind = 2; q.push_back(e);
        busy_lo  = tc;
        busy_hi  = d - 1;
        m_done   = d;
        m_active = 1'b1;
    endtask

    task automatic truncate(input int c);
        ev_t keep[$];
        foreach (q[i]) if (q[i].cyc <= c) keep.push_back(q[i]);
        q = keep;
        if (busy_hi > c) busy_hi = c;
        m_active = 1'b0;
    endtask

    function automatic bit model_idle(input int c);
`ifdef COUNTER_GATE_AUTORELOAD_EN
        return !m_active;
`else
        return !m_active || (c > m_done);
`endif
    endfunction

    // Drive one cycle of inputs, update the model, advance to just after the next rising edge.
    task automatic step(input bit st, input bit sp, input bit rs, input int p, input int w);
        int c;
        c = cyc;
        bus.i_start    = st;
        bus.i_stop     = sp;
        rst            = rs;
        bus.i_prescale = PW'(p);
        bus.i_window   = WW'(w);
        if (rs || sp) begin
            truncate(c);
        end else begin
`ifdef COUNTER_GATE_AUTORELOAD_EN
            if (m_active && (c == m_done)) sched(c + 1, m_p, m_w);
`endif
            if (st && model_idle(c)) begin
                m_p = p;
                m_w = w;
                sched(c + 1, p, w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 9));
    endtask

    // Monitor: pops the events due this cycle and compares every output.
    always @(negedge clk) begin
        logic ee, ec, ed;
        if (cyc >= 1) begin
            ee = 1'b0; ec = 1'b0; ed = 1'b0;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                if (q[0].cyc < cyc) $display("FAIL stale_event cycle %0d: got event of kind %0d left unmatched, required none", q[0].cyc, q[0].kind);
                else if (q[0].kind == 0) ec = 1'b1;
                else if (q[0].kind == 1) ee = 1'b1;
                else ed = 1'b1;
                void'(q.pop_front());
            end
            chk("o_clear", bus.o_clear, ec);
            chk("o_en", bus.o_en, ee);
            chk("o_done", bus.o_done, ed);
            chk("o_busy", bus.o_busy, (cyc >= busy_lo) && (cyc <= busy_hi));
        end
    end

    initial begin
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_prescale = '0; bus.i_window = '0; rst = 1'b1;
        // Reset held 3 cycles with start high; start accepted on the first cycle out of reset.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 2, 3);
        step(1'b1, 1'b0, 1'b0, 2, 3);
        idle(14);
        // Prescale 0: one strobe per RUN cycle.
        step(1'b1, 1'b0, 1'b0, 0, 4);
        idle(9);
        // Empty window: clear then done, no strobes.
        step(1'b1, 1'b0, 1'b0, 5, 0);
        idle(4);
        // Abort mid-run after two strobes.
        step(1'b1, 1'b0, 1'b0, 1, 5);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 1, 5);
        idle(4);
        // Start and stop together in IDLE.
        step(1'b1, 1'b1, 1'b0, 0, 1);
        idle(3);
        // Start pulses and parameter changes during a run are ignored.
        step(1'b1, 1'b0, 1'b0, 3, 3);
        for (int i = 0; i < 14; i++) step(i[0], 1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(1, 9));
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(3);
        // Reset mid-run.
        step(1'b1, 1'b0, 1'b0, 1, 5);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1, 5);
        idle(3);
        // Two short windows, then stop (back-to-back when autoreload is built in).
        step(1'b1, 1'b0, 1'b0, 0, 2);
        idle(8);
        step(1'b0, 1'b1, 1'b0, 0, 2);
        idle(3);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 4), $urandom_range(0, 6));
        end
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(5);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) $display("FAIL queue_drain: got %0d pending events, required 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
